// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with ack handshake, sweep-release pulse and hold timeout
// A release picks the next candidate from the requesters above the served index, wrapping on sweep end.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int AW       = $clog2(N),
    parameter int HOLD_MAX = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [N-1:0]  req_i,
    input  logic          ack_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o,
    output logic [AW-1:0] add_o,
    output logic          grp_release_o,
    output logic          timeout_o
);

    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [AW-1:0]   add_q, add_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            valid_q, valid_d;
    logic            grp_q, grp_d;
    logic            to_q, to_d;

    logic [N-1:0]    nxt_mask, sel_mask, masked;
    logic [AW-1:0]   cand_idx;
    logic [N-1:0]    cand_onehot;
    logic            cand_any, sweep_end;
    logic            to_hit, rel_ack, rel_to, release_ev;

    function automatic logic [AW-1:0] lowest(input logic [N-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = AW'(i);
        end
        return r;
    endfunction

    // Candidate search is shared by the idle grant and the zero-bubble handover on release.
    always_comb begin
        nxt_mask = '0;
        for (int i = 0; i < N; i++) begin
            nxt_mask[i] = (32'(i) > 32'(add_q));
        end
        sel_mask    = (state_q == IDLE) ? mask_q : nxt_mask;
        masked      = req_i & sel_mask;
        cand_any    = |req_i;
        cand_idx    = (|masked) ? lowest(masked) : lowest(req_i);
        cand_onehot = {{(N-1){1'b0}}, 1'b1} << cand_idx;
        sweep_end   = ~|(req_i & nxt_mask);
        to_hit      = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_MAX - 1));
        rel_ack     = (state_q == GRANT) && enable && ack_i;
        rel_to      = (state_q == GRANT) && enable && !ack_i && to_hit;
        release_ev  = rel_ack || rel_to;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= '1;
            gnt_q   <= '0;
            add_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            grp_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            gnt_q   <= gnt_d;
            add_q   <= add_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            grp_q   <= grp_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && cand_any) state_d = GRANT;
            GRANT:   if (release_ev && !cand_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        gnt_d  = gnt_q;
        add_d  = add_q;
        hold_d = hold_q;
        grp_d  = 1'b0;
        to_d   = 1'b0;
        if (state_q == IDLE) begin
            if (enable && cand_any) begin
                gnt_d  = cand_onehot;
                add_d  = cand_idx;
                hold_d = '0;
            end
        end else if (release_ev) begin
            mask_d = sweep_end ? '1 : nxt_mask;
            grp_d  = sweep_end;
            to_d   = rel_to;
            hold_d = '0;
            gnt_d  = cand_any ? cand_onehot : '0;
            add_d  = cand_any ? cand_idx : '0;
        end else if (enable) begin
            hold_d = hold_q + 1'b1;
        end
        valid_d = |gnt_d;
    end

    assign gnt_o         = gnt_q;
    assign valid_o       = valid_q;
    assign add_o         = add_q;
    assign grp_release_o = grp_q;
    assign timeout_o     = to_q;

endmodule
